// File: rtl/reg_scoreboard.sv
// Register scoreboard: one pending bit per architectural register, with a
// same-cycle release bypass to the decode lookups, plus occupancy, stall and sticky error tracking.
module reg_scoreboard #(
    parameter int N_REG = 8,
    parameter int W_RD  = 3,
    parameter int W_SC  = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            lookup_v_i,
    input  logic [W_RD-1:0] rd_name_i,
    input  logic [W_RD-1:0] rs_name_i,
    input  logic            rs_used_i,
    output logic            rd_reserved_o,
    output logic            rs_reserved_o,
    input  logic            reserve_i,
    input  logic            release_i,
    input  logic [W_RD-1:0] release_name_i,
    input  logic            flush_i,
    output logic [W_RD:0]   busy_cnt_o,
    output logic            all_clear_o,
    output logic [W_SC-1:0] stall_cnt_o,
    output logic [1:0]      err_o
);

    logic [N_REG-1:0] bitmap_r;
    logic [N_REG-1:0] bitmap_next_s;
    logic [N_REG-1:0] rel_mask_s;
    logic [N_REG-1:0] res_mask_s;
    logic [W_RD:0]    busy_cnt_r;
    logic             all_clear_r;
    logic [W_SC-1:0]  stall_cnt_r;
    logic [1:0]       err_r;
    logic             rel_hits_rd_s;
    logic             rel_hits_rs_s;
    logic             dbl_res_s;
    logic             bad_rel_s;
    logic             hazard_s;

    function automatic logic [W_RD:0] pop_count(input logic [N_REG-1:0] vec);
        logic [W_RD:0] cnt;
        cnt = {(W_RD+1){1'b0}};
        for (int i = 0; i < N_REG; i++) begin
            cnt = cnt + (W_RD+1)'(vec[i]);
        end
        return cnt;
    endfunction

    // A release retiring in this cycle is hidden from both lookups (bypass).
    assign rel_hits_rd_s = release_i & (release_name_i == rd_name_i);
    assign rel_hits_rs_s = release_i & (release_name_i == rs_name_i);
    assign rd_reserved_o = bitmap_r[rd_name_i] & ~rel_hits_rd_s;
    assign rs_reserved_o = rs_used_i & bitmap_r[rs_name_i] & ~rel_hits_rs_s;
    assign hazard_s      = lookup_v_i & (rd_reserved_o | rs_reserved_o);

    assign dbl_res_s = ~flush_i & reserve_i & bitmap_r[rd_name_i] & ~rel_hits_rd_s;
    assign bad_rel_s = ~flush_i & release_i & ~bitmap_r[release_name_i];

    // Set after clear, so a same-register reserve+release leaves the new writer pending.
    assign rel_mask_s    = release_i ? ({{(N_REG-1){1'b0}}, 1'b1} << release_name_i) : {N_REG{1'b0}};
    assign res_mask_s    = reserve_i ? ({{(N_REG-1){1'b0}}, 1'b1} << rd_name_i) : {N_REG{1'b0}};
    assign bitmap_next_s = flush_i ? {N_REG{1'b0}} : ((bitmap_r & ~rel_mask_s) | res_mask_s);

    // State, occupancy summary, stall counter and sticky errors.
    always_ff @(posedge clk) begin
        if (rst) begin
            bitmap_r    <= {N_REG{1'b0}};
            busy_cnt_r  <= {(W_RD+1){1'b0}};
            all_clear_r <= 1'b1;
            stall_cnt_r <= {W_SC{1'b0}};
            err_r       <= 2'b00;
        end else begin
            bitmap_r    <= bitmap_next_s;
            busy_cnt_r  <= pop_count(bitmap_next_s);
            all_clear_r <= ~|bitmap_next_s;
            if (hazard_s && !(&stall_cnt_r)) begin
                stall_cnt_r <= stall_cnt_r + {{(W_SC-1){1'b0}}, 1'b1};
            end
            err_r       <= err_r | {bad_rel_s, dbl_res_s};
        end
    end

    assign busy_cnt_o  = busy_cnt_r;
    assign all_clear_o = all_clear_r;
    assign stall_cnt_o = stall_cnt_r;
    assign err_o       = err_r;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Scoreboard bench for reg_scoreboard: directed scenarios then random traffic,
// compared against a register-array reference model through an expectation queue.
module tb_reg_scoreboard;

    localparam int N_REG     = 8;
    localparam int W_RD      = 3;
    localparam int W_SC      = 8;
    localparam int STALL_MAX = (1 << W_SC) - 1;

    logic            clk;
    logic            rst;
    logic            lookup_v_i;
    logic [W_RD-1:0] rd_name_i;
    logic [W_RD-1:0] rs_name_i;
    logic            rs_used_i;
    logic            rd_reserved_o;
    logic            rs_reserved_o;
    logic            reserve_i;
    logic            release_i;
    logic [W_RD-1:0] release_name_i;
    logic            flush_i;
    logic [W_RD:0]   busy_cnt_o;
    logic            all_clear_o;
    logic [W_SC-1:0] stall_cnt_o;
    logic [1:0]      err_o;

    reg_scoreboard #(.N_REG(N_REG), .W_RD(W_RD), .W_SC(W_SC)) dut (
        .clk(clk), .rst(rst), .lookup_v_i(lookup_v_i), .rd_name_i(rd_name_i),
        .rs_name_i(rs_name_i), .rs_used_i(rs_used_i), .rd_reserved_o(rd_reserved_o),
        .rs_reserved_o(rs_reserved_o), .reserve_i(reserve_i), .release_i(release_i),
        .release_name_i(release_name_i), .flush_i(flush_i), .busy_cnt_o(busy_cnt_o),
        .all_clear_o(all_clear_o), .stall_cnt_o(stall_cnt_o), .err_o(err_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit       rd_res;
        bit       rs_res;
        int       busy;
        bit       clr;
        int       stall;
        bit [1:0] err;
    } exp_t;

    exp_t q[$];
    int n_vec = 0;
    int n_bad = 0;

    // Reference model state
    bit       pend[N_REG];
    int       m_stall;
    bit [1:0] m_err;

    function automatic void check(string name, int act, int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Apply one cycle of inputs at the falling edge and queue the model's expectation.
    task automatic cyc(input bit r, input bit lv, input int rd, input int rs, input bit used,
                       input bit res, input bit rel, input int rn, input bit fl);
        exp_t e;
        bit   rd_hit;
        bit   rs_hit;
        bit   old_rd;
        bit   old_rn;
        int   cnt;
        @(negedge clk);
        rst = r; lookup_v_i = lv; rd_name_i = W_RD'(rd); rs_name_i = W_RD'(rs);
        rs_used_i = used; reserve_i = res; release_i = rel; release_name_i = W_RD'(rn);
        flush_i = fl;
        rd_hit   = pend[rd] && !(rel && rn == rd);
        rs_hit   = used && pend[rs] && !(rel && rn == rs);
        e.rd_res = rd_hit;
        e.rs_res = rs_hit;
        if (r) begin
            foreach (pend[i]) pend[i] = 1'b0;
            m_stall = 0;
            m_err   = 2'b00;
        end else begin
            if (lv && (rd_hit || rs_hit) && m_stall < STALL_MAX) m_stall++;
            if (fl) begin
                foreach (pend[i]) pend[i] = 1'b0;
            end else begin
                old_rd = pend[rd];
                old_rn = pend[rn];
                if (res && old_rd && !(rel && rn == rd)) m_err[0] = 1'b1;
                if (rel && !old_rn) m_err[1] = 1'b1;
                if (rel) pend[rn] = 1'b0;
                if (res) pend[rd] = 1'b1;
            end
        end
        cnt = 0;
        foreach (pend[i]) cnt += int'(pend[i]);
        e.busy  = cnt;
        e.clr   = (cnt == 0);
        e.stall = m_stall;
        e.err   = m_err;
        q.push_back(e);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic reserve(input int r);
        cyc(1'b0, 1'b0, r, 0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    endtask

    // Monitor: lookups just before the rising edge, registered outputs just after it.
    initial begin
        exp_t e;
        bit   a_rd;
        bit   a_rs;
        forever begin
            @(negedge clk);
            #4;
            if (q.size() > 0) begin
                e = q.pop_front();
                a_rd = rd_reserved_o;
                a_rs = rs_reserved_o;
                @(posedge clk);
                #1;
                check("rd_reserved", int'(a_rd), int'(e.rd_res));
                check("rs_reserved", int'(a_rs), int'(e.rs_res));
                check("busy_cnt", int'(busy_cnt_o), e.busy);
                check("all_clear", int'(all_clear_o), int'(e.clr));
                check("stall_cnt", int'(stall_cnt_o), e.stall);
                check("err", int'(err_o), int'(e.err));
            end
        end
    end

    initial begin
        rst = 1'b1; lookup_v_i = 1'b0; rd_name_i = '0; rs_name_i = '0; rs_used_i = 1'b0;
        reserve_i = 1'b0; release_i = 1'b0; release_name_i = '0; flush_i = 1'b0;
        foreach (pend[i]) pend[i] = 1'b0;
        m_stall = 0;
        m_err   = 2'b00;
        repeat (2) @(posedge clk);

        // Reset state, then reserve r3 / look it up / release it
        idle();
        reserve(3);
        cyc(1'b0, 1'b1, 3, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        cyc(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 3, 1'b0);
        // Same-cycle release bypass on rs
        reserve(5);
        cyc(1'b0, 1'b1, 0, 5, 1'b1, 1'b0, 1'b1, 5, 1'b0);
        // Reserve+release of the same register, then a genuine double reserve
        reserve(2);
        cyc(1'b0, 1'b0, 2, 0, 1'b0, 1'b1, 1'b1, 2, 1'b0);
        idle();
        reserve(2);
        // Release of a clear register, fill all, flush overriding a reserve
        cyc(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 7, 1'b0);
        for (int i = 0; i < N_REG; i++) reserve(i);
        idle();
        cyc(1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 4, 1'b1);
        // Different-register reserve and release together
        reserve(1);
        cyc(1'b0, 1'b0, 6, 0, 1'b0, 1'b1, 1'b1, 1, 1'b0);
        // Stall counting on rs, no count when rs unused, then saturation
        reserve(4);
        repeat (3) cyc(1'b0, 1'b1, 0, 4, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        repeat (2) cyc(1'b0, 1'b1, 0, 4, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        repeat (STALL_MAX + 4) cyc(1'b0, 1'b1, 4, 4, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        // Reset mid-operation with reservations and both errors set
        cyc(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        for (int i = 0; i < 4; i++) reserve(i);
        reserve(0);
        cyc(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 7, 1'b0);
        cyc(1'b1, 1'b1, 0, 1, 1'b1, 1'b1, 1'b1, 2, 1'b0);
        idle();

        // Randomised traffic
        for (int n = 0; n < 2000; n++) begin
            cyc(($urandom_range(0, 99) == 0), 1'($urandom), int'($urandom_range(0, N_REG - 1)),
                int'($urandom_range(0, N_REG - 1)), 1'($urandom), ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 2) == 0), int'($urandom_range(0, N_REG - 1)),
                ($urandom_range(0, 24) == 0));
        end

        for (int t = 0; t < 10 && q.size() > 0; t++) @(posedge clk);
        repeat (2) @(posedge clk);
        if (q.size() > 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
